// File: rtl/alu_stage_pipe_pkg.sv
// Shared opcode and state encodings for the pipelined ALU execute stage,
// plus small opcode-classification helpers.
package alu_stage_pipe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOTA = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic op_err;
    } alu_flags_t;

    function automatic logic is_shift_op(input logic [3:0] func);
        logic r_s;
        case (func)
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: r_s = 1'b1;
            default:                                     r_s = 1'b0;
        endcase
        return r_s;
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] func);
        logic r_s;
        case (func)
            4'b1011, 4'b1110, 4'b1111: r_s = 1'b1;
            default:                   r_s = 1'b0;
        endcase
        return r_s;
    endfunction

endpackage

// File: rtl/alu_stage_pipe_core.sv
// Combinational ALU datapath: single-cycle ops with overflow/illegal detect,
// and the one-bit shift/rotate step used by the iterative shifter.
module alu_core
    import alu_stage_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] step_in,
    input  logic [3:0]       step_func,
    output logic [WIDTH-1:0] res,
    output logic             ovf,
    output logic             op_err,
    output logic [WIDTH-1:0] step_out
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_neg_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    assign b_neg_s = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign sum_s   = a + b;
    assign diff_s  = a + b_neg_s;
    assign op_err  = is_illegal_op(func);

    // Single-cycle result; shift ops land here only with a zero amount, so they pass A.
    always_comb begin
        res = {WIDTH{1'b0}};
        ovf = 1'b0;
        case (func)
            ALU_ADD: begin
                res = sum_s;
                ovf = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                res = diff_s;
                ovf = (a[MSB] == b_neg_s[MSB]) && (diff_s[MSB] != a[MSB]);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_NOTA: res = ~a;
            ALU_NAND: res = ~(a & b);
            ALU_NOR:  res = ~(a | b);
            ALU_XOR:  res = a ^ b;
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: res = a;
            default:  res = {WIDTH{1'b0}};
        endcase
    end

    // One-bit step of the latched shift/rotate.
    always_comb begin
        step_out = step_in;
        case (step_func)
            ALU_SRA: step_out = {step_in[MSB], step_in[MSB:1]};
            ALU_SRL: step_out = {1'b0, step_in[MSB:1]};
            ALU_SLL: step_out = {step_in[MSB-1:0], 1'b0};
            ALU_ROL: step_out = {step_in[MSB-1:0], step_in[MSB]};
            ALU_ROR: step_out = {step_in[0], step_in[MSB:1]};
            default: step_out = step_in;
        endcase
    end

endmodule

// File: rtl/alu_stage_pipe.sv
// Registered ALU execute stage with valid/ready handshakes and an iterative
// one-bit-per-cycle shifter for variable-amount shifts and rotates.
module alu_stage_pipe
    import alu_stage_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] RF_A,
    input  logic [WIDTH-1:0] RF_B,
    input  logic [WIDTH-1:0] Immed,
    input  logic             ALU_Bin_sel,
    input  logic [3:0]       ALU_func,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Zero,
    output logic             Ovf,
    output logic             Op_err,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Busy
);

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [0:0]         state_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   work_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   alu_out_r;
    alu_flags_t         flags_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   b_op_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   core_res_s;
    logic [WIDTH-1:0]   step_out_s;
    logic               core_ovf_s;
    logic               core_err_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               start_shift_s;
    logic               finish_s;
    logic               load_s;
    logic [WIDTH-1:0]   load_val_s;
    alu_flags_t         load_flags_s;

    assign b_op_s  = ALU_Bin_sel ? Immed : RF_B;
    assign shamt_s = b_op_s[SHAMT_W-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a         (RF_A),
        .b         (b_op_s),
        .func      (ALU_func),
        .step_in   (work_r),
        .step_func (op_r),
        .res       (core_res_s),
        .ovf       (core_ovf_s),
        .op_err    (core_err_s),
        .step_out  (step_out_s)
    );

    // SHIFT entry requires a free output slot, so the final write never overwrites an unread result.
    assign in_ready_s    = (state_r == ST_IDLE) && (!out_valid_r || Out_ready);
    assign accept_s      = In_valid && in_ready_s;
    assign start_shift_s = accept_s && is_shift_op(ALU_func) && (shamt_s != CNT_ZERO);
    assign finish_s      = (state_r == ST_SHIFT) && (cnt_r == CNT_ONE);
    assign load_s        = (accept_s && !start_shift_s) || finish_s;

    // Select what the output register captures: immediate result or last shift step.
    always_comb begin
        load_val_s   = core_res_s;
        load_flags_s = '{zero: 1'b0, ovf: 1'b0, op_err: 1'b0};
        if (finish_s) begin
            load_val_s          = step_out_s;
            load_flags_s.zero   = (step_out_s == {WIDTH{1'b0}});
            load_flags_s.ovf    = 1'b0;
            load_flags_s.op_err = 1'b0;
        end else begin
            load_val_s          = core_res_s;
            load_flags_s.zero   = (core_res_s == {WIDTH{1'b0}});
            load_flags_s.ovf    = core_ovf_s;
            load_flags_s.op_err = core_err_s;
        end
    end

    // Shift FSM: latch operands on entry, step once per cycle until the count runs out.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            work_r  <= {WIDTH{1'b0}};
            op_r    <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_shift_s) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= shamt_s;
                        work_r  <= RF_A;
                        op_r    <= ALU_func;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_r <= step_out_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: result and flags load together; held while the consumer stalls.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            alu_out_r   <= {WIDTH{1'b0}};
            flags_r     <= '{zero: 1'b0, ovf: 1'b0, op_err: 1'b0};
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            alu_out_r   <= load_val_s;
            flags_r     <= load_flags_s;
            out_valid_r <= 1'b1;
        end else if (Out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign In_ready  = in_ready_s;
    assign ALU_out   = alu_out_r;
    assign Zero      = flags_r.zero;
    assign Ovf       = flags_r.ovf;
    assign Op_err    = flags_r.op_err;
    assign Out_valid = out_valid_r;
    assign Busy      = (state_r != ST_IDLE);

endmodule
